spi_xchg_ctrl: RTL and testbench

SPI_XCHG_CTRL -- requirements
Module: spi_xchg_ctrl

---
 rtl/spi_xchg_ctrl.sv | 167 ++++++++++++++++
 tb/tb_spi_xchg_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xchg_ctrl.sv
// spi_xchg_ctrl
// ----------------------------------------------------------------------------
// Loopback SPI exchange controller. It models both ends of a 16-bit
// full-duplex SPI link (mode 0, MSB first): a master shift register (msr) and
// a slave shift register (ssr) trade their contents over 16 SCLK periods.
// The received words are captured when the exchange completes.
//
// Ports
//   clk         system clock; all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   start       request one exchange (seen only in IDLE)
//   abort       cancel an exchange in LOAD or SHIFT
//   MASTER_dat  master transmit word, captured in LOAD
//   SLAVE_dat   slave transmit word, captured in LOAD
//   SCLK        serial clock, idle low, half-period of DIV clk cycles
//   cs_n        select, low only while shifting
//   MOSI        msr[15]
//   MISO        ssr[15]
//   busy        high in LOAD, SHIFT and DONE
//   done        one-cycle pulse when an exchange completes
//   master_rx   word received by the master at the last completed exchange
//   slave_rx    word received by the slave at the last completed exchange
//   state_dbg   current FSM state (0 IDLE, 1 LOAD, 2 SHIFT, 3 DONE)
//
// Handshake: start is a request level sampled once per clock while idle; it
// is neither queued nor acknowledged other than by busy going high on the
// next cycle. done pulses for exactly one cycle and master_rx/slave_rx are
// valid from that cycle until the next completed exchange.
// ----------------------------------------------------------------------------
module spi_xchg_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] MASTER_dat,
  input  logic [15:0] SLAVE_dat,
  output logic        SCLK,
  output logic        cs_n,
  output logic        MOSI,
  output logic        MISO,
  output logic        busy,
  output logic        done,
  output logic [15:0] master_rx,
  output logic [15:0] slave_rx,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t      state;
  logic [15:0] msr;
  logic [15:0] ssr;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic        m_in;
  logic        s_in;
  logic [15:0] msr_nxt;
  logic [15:0] ssr_nxt;

  // Bits captured on the SCLK rise are shifted in on the following fall.
  assign msr_nxt   = {msr[14:0], m_in};
  assign ssr_nxt   = {ssr[14:0], s_in};
  assign MOSI      = msr[15];
  assign MISO      = ssr[15];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      msr       <= 16'h0000;
      ssr       <= 16'h0000;
      div_cnt   <= 8'd0;
      bit_cnt   <= 4'd0;
      m_in      <= 1'b0;
      s_in      <= 1'b0;
      SCLK      <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      master_rx <= 16'h0000;
      slave_rx  <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort beats a simultaneous start
          if (start && !abort) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end

        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            cs_n  <= 1'b1;
            SCLK  <= 1'b0;
          end else begin
            msr     <= MASTER_dat;
            ssr     <= SLAVE_dat;
            div_cnt <= 8'd0;
            bit_cnt <= 4'd0;
            cs_n    <= 1'b0;
            SCLK    <= 1'b0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            cs_n  <= 1'b1;
            SCLK  <= 1'b0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            SCLK    <= ~SCLK;
            if (!SCLK) begin
              // rising edge: both ends sample the other's MSB
              m_in <= ssr[15];
              s_in <= msr[15];
            end else begin
              // falling edge: both ends shift
              msr <= msr_nxt;
              ssr <= ssr_nxt;
              if (bit_cnt == 4'd15) begin
                // bit_cnt holds at 15 rather than wrapping; LOAD clears it
                state     <= DONE;
                cs_n      <= 1'b1;
                master_rx <= msr_nxt;
                slave_rx  <= ssr_nxt;
                done      <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cs_n  <= 1'b1;
          SCLK  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xchg_ctrl.sv
// tb_spi_xchg_ctrl
// Directed bench for spi_xchg_ctrl: one instance with DIV=4 for the main
// scenarios and one with DIV=1 for the held-start back-to-back case.
// Inputs are driven on the falling clock edge, outputs sampled there too.
// Cycle numbering: edge 0 is the rising edge that samples start; observation
// n is taken at the falling edge after rising edge n.
module tb_spi_xchg_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] mdat, sdat;
  logic        sclk, cs_n, mosi, miso, busy, done;
  logic [15:0] master_rx, slave_rx;
  logic [1:0]  state_dbg;

  logic        start1;
  logic [15:0] mdat1, sdat1;
  logic        sclk1, cs_n1, mosi1, miso1, busy1, done1;
  logic [15:0] master_rx1, slave_rx1;
  logic [1:0]  state_dbg1;

  int checks;
  int errors;

  spi_xchg_ctrl #(.DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .MASTER_dat(mdat), .SLAVE_dat(sdat),
    .SCLK(sclk), .cs_n(cs_n), .MOSI(mosi), .MISO(miso),
    .busy(busy), .done(done), .master_rx(master_rx), .slave_rx(slave_rx),
    .state_dbg(state_dbg)
  );

  spi_xchg_ctrl #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .MASTER_dat(mdat1), .SLAVE_dat(sdat1),
    .SCLK(sclk1), .cs_n(cs_n1), .MOSI(mosi1), .MISO(miso1),
    .busy(busy1), .done(done1), .master_rx(master_rx1), .slave_rx(slave_rx1),
    .state_dbg(state_dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one exchange on the DIV=4 instance starting at a falling edge and
  // records what it observed. With disturb set, start is re-pulsed at n=40
  // and MASTER_dat is changed to FFFF at n=50 (both mid-SHIFT).
  task automatic run_xchg(input logic [15:0] m, input logic [15:0] s,
                          input bit disturb, input int n_max,
                          output int first_done, output int n_done,
                          output int rises, output logic [15:0] mosi_w,
                          output logic [15:0] miso_w, output int cs_bad);
    logic sclk_prev;
    first_done = -1; n_done = 0; rises = 0; cs_bad = 0;
    mosi_w = 16'h0; miso_w = 16'h0; sclk_prev = 1'b0;
    mdat = m; sdat = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= n_max; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = n;
      end
      if (sclk && !sclk_prev) begin
        rises++;
        mosi_w = {mosi_w[14:0], mosi};
        miso_w = {miso_w[14:0], miso};
      end
      sclk_prev = sclk;
      if (n <= 128 && cs_n !== 1'b0) cs_bad++;
      if (n >= 129 && cs_n !== 1'b1) cs_bad++;
      if (disturb) begin
        if (n == 40) start = 1'b1;
        if (n == 41) start = 1'b0;
        if (n == 50) mdat = 16'hFFFF;
      end
    end
    mdat = 16'h0000; sdat = 16'h0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mdat = 16'h0; sdat = 16'h0;
    start1 = 1'b0; mdat1 = 16'h0; sdat1 = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", sclk); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b exp 1", cs_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if ({mosi, miso} !== 2'b00) begin errors++; $display("FAIL reset_mosi_miso got %b exp 00", {mosi, miso}); end
    checks++; if (master_rx !== 16'h0000) begin errors++; $display("FAIL reset_master_rx got %h exp 0000", master_rx); end
    checks++; if (slave_rx !== 16'h0000) begin errors++; $display("FAIL reset_slave_rx got %h exp 0000", slave_rx); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
  endtask

  task automatic test_basic();
    int fd, nd, rs, csb;
    logic [15:0] mw, sw;
    run_xchg(16'h1234, 16'h5678, 1'b0, 140, fd, nd, rs, mw, sw, csb);
    checks++; if (fd !== 129) begin errors++; $display("FAIL basic_done_cycle got %0d exp 129", fd); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", nd); end
    checks++; if (rs !== 16) begin errors++; $display("FAIL basic_sclk_rises got %0d exp 16", rs); end
    checks++; if (master_rx !== 16'h5678) begin errors++; $display("FAIL basic_master_rx got %h exp 5678", master_rx); end
    checks++; if (slave_rx !== 16'h1234) begin errors++; $display("FAIL basic_slave_rx got %h exp 1234", slave_rx); end
    checks++; if (mw !== 16'h1234) begin errors++; $display("FAIL basic_mosi_word got %h exp 1234", mw); end
    checks++; if (sw !== 16'h5678) begin errors++; $display("FAIL basic_miso_word got %h exp 5678", sw); end
    checks++; if (csb !== 0) begin errors++; $display("FAIL basic_cs_n_window got %0d bad cycles exp 0", csb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_disturb();
    int fd, nd, rs, csb;
    logic [15:0] mw, sw;
    // clear the rx words first so the check below proves a fresh capture
    run_xchg(16'h0000, 16'h0000, 1'b0, 135, fd, nd, rs, mw, sw, csb);
    checks++; if (master_rx !== 16'h0000) begin errors++; $display("FAIL zero_master_rx got %h exp 0000", master_rx); end
    run_xchg(16'h1234, 16'h5678, 1'b1, 140, fd, nd, rs, mw, sw, csb);
    checks++; if (nd !== 1) begin errors++; $display("FAIL disturb_done_count got %0d exp 1", nd); end
    checks++; if (fd !== 129) begin errors++; $display("FAIL disturb_done_cycle got %0d exp 129", fd); end
    checks++; if (master_rx !== 16'h5678) begin errors++; $display("FAIL disturb_master_rx got %h exp 5678", master_rx); end
    checks++; if (slave_rx !== 16'h1234) begin errors++; $display("FAIL disturb_slave_rx got %h exp 1234", slave_rx); end
    checks++; if (mw !== 16'h1234) begin errors++; $display("FAIL disturb_mosi_word got %h exp 1234", mw); end
  endtask

  task automatic test_abort();
    int nd;
    nd = 0;
    mdat = 16'hAAAA; sdat = 16'h5555; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) nd++;
      // 7th SCLK fall is toggle 14, at edge 1+14*4 = 57
      if (n == 57) begin
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL abort_pre_cs_n got %b exp 0", cs_n); end
        abort = 1'b1;
      end
      if (n == 58) begin
        abort = 1'b0;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL abort_cs_n got %b exp 1", cs_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk got %b exp 0", sclk); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", state_dbg); end
      end
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", nd); end
    checks++; if (master_rx !== 16'h5678) begin errors++; $display("FAIL abort_master_rx got %h exp 5678", master_rx); end
    checks++; if (slave_rx !== 16'h1234) begin errors++; $display("FAIL abort_slave_rx got %h exp 1234", slave_rx); end
    // abort and start together in IDLE: stay idle
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle busy got %b exp 0", busy); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL abort_start_idle state got %0d exp 0", state_dbg); end
  endtask

  task automatic test_reset_mid();
    int fd, nd, rs, csb;
    logic [15:0] mw, sw;
    mdat = 16'hAAAA; sdat = 16'h5555; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got %b exp 0", sclk); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n got %b exp 1", cs_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if ({mosi, miso} !== 2'b00) begin errors++; $display("FAIL rstmid_mosi_miso got %b exp 00", {mosi, miso}); end
    checks++; if (master_rx !== 16'h0000) begin errors++; $display("FAIL rstmid_master_rx got %h exp 0000", master_rx); end
    checks++; if (slave_rx !== 16'h0000) begin errors++; $display("FAIL rstmid_slave_rx got %h exp 0000", slave_rx); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rstmid_state got %0d exp 0", state_dbg); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_xchg(16'hC3C3, 16'h3C3C, 1'b0, 135, fd, nd, rs, mw, sw, csb);
    checks++; if (fd !== 129) begin errors++; $display("FAIL rstmid_after_done_cycle got %0d exp 129", fd); end
    checks++; if (master_rx !== 16'h3C3C) begin errors++; $display("FAIL rstmid_after_master_rx got %h exp 3c3c", master_rx); end
    checks++; if (slave_rx !== 16'hC3C3) begin errors++; $display("FAIL rstmid_after_slave_rx got %h exp c3c3", slave_rx); end
  endtask

  task automatic test_back_to_back();
    int dn [0:3];
    int cnt;
    cnt = 0;
    for (int i = 0; i < 4; i++) dn[i] = -1;
    mdat1 = 16'hA5A5; sdat1 = 16'h0F0F; start1 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 105; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1) begin
        if (cnt < 4) dn[cnt] = n;
        cnt++;
      end
    end
    start1 = 1'b0;
    checks++; if (cnt !== 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", cnt); end
    checks++; if (dn[0] !== 33) begin errors++; $display("FAIL b2b_done0 got %0d exp 33", dn[0]); end
    checks++; if (dn[1] !== 68) begin errors++; $display("FAIL b2b_done1 got %0d exp 68", dn[1]); end
    checks++; if (dn[2] !== 103) begin errors++; $display("FAIL b2b_done2 got %0d exp 103", dn[2]); end
    checks++; if (master_rx1 !== 16'h0F0F) begin errors++; $display("FAIL b2b_master_rx got %h exp 0f0f", master_rx1); end
    checks++; if (slave_rx1 !== 16'hA5A5) begin errors++; $display("FAIL b2b_slave_rx got %h exp a5a5", slave_rx1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_disturb();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
